// File: rtl/bcd_clock_core_if.sv
// Command/load/alarm inputs and display outputs of the BCD time-of-day core.
// The controller uses master; the core itself uses slave.
interface bcd_clock_core_if;
   logic       clear;
   logic       start_stop;
   logic       load;
   logic [7:0] load_hour;
   logic [7:0] load_min;
   logic [7:0] load_sec;
   logic       load_pm;
   logic       alarm_en;
   logic [7:0] alarm_hour;
   logic [7:0] alarm_min;
   logic       alarm_pm;
   logic [3:0] sec_h;
   logic [3:0] sec_l;
   logic [3:0] min_h;
   logic [3:0] min_l;
   logic [3:0] hour_h;
   logic [3:0] hour_l;
   logic       pm;
   logic       running;
   logic       day_carry;
   logic       alarm_hit;
   logic       load_err;

   modport master (
      output clear, start_stop, load, load_hour, load_min, load_sec, load_pm,
             alarm_en, alarm_hour, alarm_min, alarm_pm,
      input  sec_h, sec_l, min_h, min_l, hour_h, hour_l, pm, running,
             day_carry, alarm_hit, load_err
   );

   modport slave (
      input  clear, start_stop, load, load_hour, load_min, load_sec, load_pm,
             alarm_en, alarm_hour, alarm_min, alarm_pm,
      output sec_h, sec_l, min_h, min_l, hour_h, hour_l, pm, running,
             day_carry, alarm_hit, load_err
   );
endinterface

// File: rtl/bcd_clock_core.sv
// Time-of-day counter: prescaler, cascaded BCD seconds/minutes/hours,
// 12/24-hour mode, range-checked load, minute alarm and day-wrap pulse.
module bcd_clock_core #(
   parameter int unsigned TICK_DIV  = 50_000_000,
   parameter int unsigned HOUR_MODE = 24
) (
   input logic            clk,
   input logic            rst_n,
   bcd_clock_core_if.slave bus
);
   localparam int            CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST      = CW'(TICK_DIV - 1);
   localparam bit            MODE12    = (HOUR_MODE == 12);
   localparam logic [7:0]    ZERO_HOUR = MODE12 ? 8'h12 : 8'h00;

   logic [CW-1:0] presc;
   logic [CW-1:0] presc_next;
   logic          running;
   logic [3:0]    sec_h, sec_l, min_h, min_l, hour_h, hour_l;
   logic          pm;
   logic          day_carry, alarm_hit, load_err;

   logic          tick;
   logic [3:0]    nsec_h, nsec_l, nmin_h, nmin_l, nhour_h, nhour_l;
   logic          npm, nday;
   logic          load_ok, alarm_match;

   assign tick       = running && (presc == LAST);
   assign presc_next = !running ? presc : ((presc == LAST) ? '0 : presc + CW'(1));

   // One-second step of the whole time; carries ripple only through full digits.
   always_comb begin
      nsec_h  = sec_h;
      nsec_l  = sec_l;
      nmin_h  = min_h;
      nmin_l  = min_l;
      nhour_h = hour_h;
      nhour_l = hour_l;
      npm     = pm;
      nday    = 1'b0;
      if (sec_l != 4'd9) begin
         nsec_l = sec_l + 4'd1;
      end else begin
         nsec_l = 4'd0;
         if (sec_h != 4'd5) begin
            nsec_h = sec_h + 4'd1;
         end else begin
            nsec_h = 4'd0;
            if (min_l != 4'd9) begin
               nmin_l = min_l + 4'd1;
            end else begin
               nmin_l = 4'd0;
               if (min_h != 4'd5) begin
                  nmin_h = min_h + 4'd1;
               end else begin
                  nmin_h = 4'd0;
                  // 12-hour: 11->12 flips pm (a pm->am flip is the day wrap), 12->01 keeps pm.
                  if (MODE12 && hour_h == 4'd1 && hour_l == 4'd2) begin
                     nhour_h = 4'd0;
                     nhour_l = 4'd1;
                  end else if (MODE12 && hour_h == 4'd1 && hour_l == 4'd1) begin
                     nhour_l = 4'd2;
                     npm     = ~pm;
                     nday    = pm;
                  end else if (!MODE12 && hour_h == 4'd2 && hour_l == 4'd3) begin
                     nhour_h = 4'd0;
                     nhour_l = 4'd0;
                     nday    = 1'b1;
                  end else if (hour_l == 4'd9) begin
                     nhour_h = hour_h + 4'd1;
                     nhour_l = 4'd0;
                  end else begin
                     nhour_l = hour_l + 4'd1;
                  end
               end
            end
         end
      end
   end

   // A load is accepted only when every digit and every field is in range.
   always_comb begin
      load_ok = (bus.load_hour[7:4] <= 4'd9) && (bus.load_hour[3:0] <= 4'd9) &&
                (bus.load_min[7:4]  <= 4'd5) && (bus.load_min[3:0]  <= 4'd9) &&
                (bus.load_sec[7:4]  <= 4'd5) && (bus.load_sec[3:0]  <= 4'd9);
      if (MODE12)
         load_ok = load_ok &&
                   (((bus.load_hour[7:4] == 4'd0) && (bus.load_hour[3:0] != 4'd0)) ||
                    ((bus.load_hour[7:4] == 4'd1) && (bus.load_hour[3:0] <= 4'd2)));
      else
         load_ok = load_ok &&
                   ((bus.load_hour[7:4] < 4'd2) ||
                    ((bus.load_hour[7:4] == 4'd2) && (bus.load_hour[3:0] <= 4'd3)));
   end

   assign alarm_match = bus.alarm_en &&
                        ({nhour_h, nhour_l} == bus.alarm_hour) &&
                        ({nmin_h, nmin_l} == bus.alarm_min) &&
                        (nsec_h == 4'd0) && (nsec_l == 4'd0) &&
                        (!MODE12 || (npm == bus.alarm_pm));

   // Priority: clear, then load (which swallows a coincident tick), then tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc     <= '0;
         running   <= 1'b0;
         sec_h     <= 4'd0;
         sec_l     <= 4'd0;
         min_h     <= 4'd0;
         min_l     <= 4'd0;
         hour_h    <= ZERO_HOUR[7:4];
         hour_l    <= ZERO_HOUR[3:0];
         pm        <= 1'b0;
         day_carry <= 1'b0;
         alarm_hit <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         day_carry <= 1'b0;
         alarm_hit <= 1'b0;
         load_err  <= 1'b0;
         if (bus.clear) begin
            presc   <= '0;
            running <= 1'b0;
            sec_h   <= 4'd0;
            sec_l   <= 4'd0;
            min_h   <= 4'd0;
            min_l   <= 4'd0;
            hour_h  <= ZERO_HOUR[7:4];
            hour_l  <= ZERO_HOUR[3:0];
            pm      <= 1'b0;
         end else begin
            if (bus.start_stop)
               running <= ~running;
            if (bus.load && load_ok) begin
               presc  <= '0;
               sec_h  <= bus.load_sec[7:4];
               sec_l  <= bus.load_sec[3:0];
               min_h  <= bus.load_min[7:4];
               min_l  <= bus.load_min[3:0];
               hour_h <= bus.load_hour[7:4];
               hour_l <= bus.load_hour[3:0];
               pm     <= MODE12 ? bus.load_pm : 1'b0;
            end else if (bus.load) begin
               presc    <= presc_next;
               load_err <= 1'b1;
            end else begin
               presc <= presc_next;
               if (tick) begin
                  sec_h     <= nsec_h;
                  sec_l     <= nsec_l;
                  min_h     <= nmin_h;
                  min_l     <= nmin_l;
                  hour_h    <= nhour_h;
                  hour_l    <= nhour_l;
                  pm        <= npm;
                  day_carry <= nday;
                  alarm_hit <= alarm_match;
               end
            end
         end
      end
   end

   assign bus.sec_h     = sec_h;
   assign bus.sec_l     = sec_l;
   assign bus.min_h     = min_h;
   assign bus.min_l     = min_l;
   assign bus.hour_h    = hour_h;
   assign bus.hour_l    = hour_l;
   assign bus.pm        = pm;
   assign bus.running   = running;
   assign bus.day_carry = day_carry;
   assign bus.alarm_hit = alarm_hit;
   assign bus.load_err  = load_err;
endmodule

// File: tb/tb_bcd_clock_core.sv
// Three cores (TICK_DIV=1/24h, TICK_DIV=4/24h, TICK_DIV=1/12h) share one stimulus stream;
// a seconds-of-day model per core feeds a queue that a per-cycle monitor drains.
module tb_bcd_clock_core;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clear = 1'b0, start_stop = 1'b0, load = 1'b0;
   logic [7:0] load_hour = 8'h00, load_min = 8'h00, load_sec = 8'h00;
   logic       load_pm = 1'b0;
   logic       alarm_en = 1'b0;
   logic [7:0] alarm_hour = 8'h00, alarm_min = 8'h00;
   logic       alarm_pm = 1'b0;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      int secs;
      int cnt;
      bit run;
      bit day;
      bit hit;
      bit err;
   } model_t;

   model_t           model [3];
   logic [2:0][28:0] exp_q [$];
   logic [28:0]      act [3];

   always #5 clk = ~clk;

   bcd_clock_core_if bus [3] ();

   for (genvar g = 0; g < 3; g++) begin : g_dut
      assign bus[g].clear      = clear;
      assign bus[g].start_stop = start_stop;
      assign bus[g].load       = load;
      assign bus[g].load_hour  = load_hour;
      assign bus[g].load_min   = load_min;
      assign bus[g].load_sec   = load_sec;
      assign bus[g].load_pm    = load_pm;
      assign bus[g].alarm_en   = alarm_en;
      assign bus[g].alarm_hour = alarm_hour;
      assign bus[g].alarm_min  = alarm_min;
      assign bus[g].alarm_pm   = alarm_pm;
      assign act[g] = {bus[g].hour_h, bus[g].hour_l, bus[g].min_h, bus[g].min_l,
                       bus[g].sec_h, bus[g].sec_l, bus[g].pm, bus[g].running,
                       bus[g].day_carry, bus[g].alarm_hit, bus[g].load_err};
      bcd_clock_core #(
         .TICK_DIV  ((g == 1) ? 4 : 1),
         .HOUR_MODE ((g == 2) ? 12 : 24)
      ) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus[g])
      );
   end

   function automatic int td_of(int i);
      return (i == 1) ? 4 : 1;
   endfunction

   function automatic bit m12_of(int i);
      return (i == 2);
   endfunction

   function automatic logic [7:0] to_bcd(int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   // Seconds since midnight for a BCD time, or -1 when any field is out of range.
   function automatic int bcd_time(logic [7:0] h, logic [7:0] mi, logic [7:0] s, logic p, bit m12);
      int hh, mm, ss;
      if (h[7:4] > 4'd9 || h[3:0] > 4'd9 || mi[7:4] > 4'd9 || mi[3:0] > 4'd9 ||
          s[7:4] > 4'd9 || s[3:0] > 4'd9)
         return -1;
      hh = int'(h[7:4]) * 10 + int'(h[3:0]);
      mm = int'(mi[7:4]) * 10 + int'(mi[3:0]);
      ss = int'(s[7:4]) * 10 + int'(s[3:0]);
      if (mm > 59 || ss > 59) return -1;
      if (m12) begin
         if (hh < 1 || hh > 12) return -1;
         hh = (hh % 12) + (p ? 12 : 0);
      end else if (hh > 23) begin
         return -1;
      end
      return hh * 3600 + mm * 60 + ss;
   endfunction

   function automatic model_t model_step(model_t m, int td, bit m12);
      model_t n;
      int     lt, at;
      bit     tick;
      n     = m;
      n.day = 1'b0;
      n.hit = 1'b0;
      n.err = 1'b0;
      if (clear) begin
         n.secs = 0;
         n.cnt  = 0;
         n.run  = 1'b0;
         return n;
      end
      tick = m.run && (m.cnt == td - 1);
      if (m.run) n.cnt = (m.cnt + 1) % td;
      if (start_stop) n.run = !m.run;
      if (load) begin
         lt = bcd_time(load_hour, load_min, load_sec, load_pm, m12);
         if (lt < 0) n.err = 1'b1;
         else begin
            n.secs = lt;
            n.cnt  = 0;
         end
      end else if (tick) begin
         n.secs = (m.secs + 1) % 86400;
         n.day  = (n.secs == 0);
         at     = bcd_time(alarm_hour, alarm_min, 8'h00, alarm_pm, m12);
         n.hit  = alarm_en && (at == n.secs);
      end
      return n;
   endfunction

   function automatic logic [28:0] expect_of(model_t m, bit m12);
      int h24, hd, mm, ss;
      h24 = m.secs / 3600;
      mm  = (m.secs / 60) % 60;
      ss  = m.secs % 60;
      hd  = m12 ? (((h24 % 12) == 0) ? 12 : h24 % 12) : h24;
      return {to_bcd(hd), to_bcd(mm), to_bcd(ss), (m12 && h24 >= 12), m.run, m.day, m.hit, m.err};
   endfunction

   task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("[TB] FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic reset_models();
      for (int i = 0; i < 3; i++) model[i] = '0;
   endtask

   // Called at a falling edge with inputs already set; predicts the next edge.
   task automatic apply_stimulus();
      logic [2:0][28:0] e;
      for (int i = 0; i < 3; i++) begin
         model[i] = model_step(model[i], td_of(i), m12_of(i));
         e[i]     = expect_of(model[i], m12_of(i));
      end
      exp_q.push_back(e);
      @(negedge clk);
      clear      = 1'b0;
      start_stop = 1'b0;
      load       = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) apply_stimulus();
   endtask

   task automatic pulse_start();
      start_stop = 1'b1;
      apply_stimulus();
   endtask

   task automatic do_clear();
      clear = 1'b1;
      apply_stimulus();
   endtask

   task automatic do_load(input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s, input logic p);
      load      = 1'b1;
      load_hour = h;
      load_min  = mi;
      load_sec  = s;
      load_pm   = p;
      apply_stimulus();
   endtask

   initial begin : monitor
      logic [2:0][28:0] e;
      int cycle;
      cycle = 0;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int i = 0; i < 3; i++)
               check_output($sformatf("sb_dut%0d_cyc%0d", i, cycle), 32'(act[i]), 32'(e[i]));
            cycle++;
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int hits [3];
      int r, hh, mm;
      reset_models();
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++)
         check_output($sformatf("reset_dut%0d", i), 32'(act[i]), 32'(expect_of(model[i], m12_of(i))));
      rst_n = 1'b1;
      @(negedge clk);

      // Free run from zero: minute steps exactly at the 60th tick.
      pulse_start();
      run(59);
      check_output("a_59s", 32'(act[0][28:5]), 32'h000059);
      run(1);
      check_output("a_1min", 32'(act[0][28:5]), 32'h000100);
      check_output("b_15s", 32'(act[1][28:5]), 32'h000015);
      check_output("c_1min", 32'(act[2][28:4]), {24'h120100, 1'b0});
      pulse_start();
      do_clear();

      // Day wrap with TICK_DIV=4.
      do_load(8'h23, 8'h59, 8'h58, 1'b0);
      pulse_start();
      run(4);
      check_output("b_235959", 32'(act[1][28:5]), 32'h235959);
      run(4);
      check_output("b_wrap", 32'(act[1][28:5]), 32'h000000);
      check_output("b_day_carry", 32'(act[1][2]), 32'd1);
      pulse_start();
      do_clear();

      // 12-hour: 11 am -> 12 pm, then 11 pm -> 12 am with day wrap.
      do_load(8'h11, 8'h59, 8'h59, 1'b0);
      pulse_start();
      run(1);
      check_output("c_noon", 32'({act[2][28:4], act[2][2]}), {24'h120000, 1'b1, 1'b0});
      pulse_start();
      do_load(8'h11, 8'h59, 8'h59, 1'b1);
      pulse_start();
      run(1);
      check_output("c_midnight", 32'({act[2][28:4], act[2][2]}), {24'h120000, 1'b0, 1'b1});
      pulse_start();
      do_clear();

      // Pause keeps the partial second.
      pulse_start();
      run(5);
      pulse_start();
      run(20);
      check_output("b_paused", 32'({act[1][28:5], act[1][3]}), {24'h000001, 1'b0});
      pulse_start();
      check_output("b_resume0", 32'(act[1][28:5]), 32'h000001);
      run(1);
      check_output("b_resume1", 32'(act[1][28:5]), 32'h000001);
      run(1);
      check_output("b_resume2", 32'(act[1][28:5]), 32'h000002);
      pulse_start();
      do_clear();

      // Rejected loads.
      do_load(8'h24, 8'h00, 8'h00, 1'b0);
      check_output("a_err_24h", 32'({act[0][28:5], act[0][0]}), {24'h000000, 1'b1});
      do_load(8'h12, 8'h5A, 8'h00, 1'b0);
      check_output("c_err_5A", 32'({act[2][28:5], act[2][0]}), {24'h120000, 1'b1});
      do_load(8'h00, 8'h00, 8'h00, 1'b0);
      check_output("c_err_00h", 32'(act[2][0]), 32'd1);
      check_output("a_ok_00h", 32'(act[0][0]), 32'd0);

      // Alarm fires once on the tick into 07:30:00.
      alarm_hour = 8'h07;
      alarm_min  = 8'h30;
      alarm_pm   = 1'b0;
      alarm_en   = 1'b1;
      do_load(8'h07, 8'h29, 8'h59, 1'b0);
      hits = '{0, 0, 0};
      pulse_start();
      for (int n = 0; n < 70; n++) begin
         apply_stimulus();
         for (int i = 0; i < 3; i++) hits[i] += int'(act[i][1]);
      end
      for (int i = 0; i < 3; i++) check_output($sformatf("alarm_once_dut%0d", i), hits[i], 1);

      // Clear beats a tick that would both wrap the day and hit the alarm.
      alarm_hour = 8'h00;
      alarm_min  = 8'h00;
      do_load(8'h23, 8'h59, 8'h59, 1'b0);
      do_clear();
      check_output("a_clear_vs_tick", 32'(act[0]), 32'h0);

      // Randomised mix of commands.
      for (int n = 0; n < 400; n++) begin
         r = int'($urandom_range(0, 63));
         if (r == 0) begin
            clear      = 1'b1;
            start_stop = 1'($urandom_range(0, 1));
         end else if (r < 6) begin
            hh = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 23));
            mm = ($urandom_range(0, 1) == 1) ? 59 : int'($urandom_range(0, 59));
            load_hour = ($urandom_range(0, 9) == 0) ? 8'($urandom) : to_bcd(hh);
            load_min  = ($urandom_range(0, 15) == 0) ? 8'($urandom) : to_bcd(mm);
            load_sec  = to_bcd(($urandom_range(0, 1) == 1) ? int'($urandom_range(50, 59)) : int'($urandom_range(0, 59)));
            load_pm   = 1'($urandom_range(0, 1));
            load      = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
               alarm_hour = load_hour;
               alarm_min  = to_bcd((mm + 1) % 60);
               alarm_pm   = load_pm;
               alarm_en   = 1'($urandom_range(0, 3) != 0);
            end
         end else if (r < 12) begin
            start_stop = 1'b1;
         end
         apply_stimulus();
      end

      // Asynchronous reset mid-count, then a short run afterwards.
      do_clear();
      pulse_start();
      run(2);
      rst_n = 1'b0;
      #1;
      reset_models();
      for (int i = 0; i < 3; i++)
         check_output($sformatf("async_reset_dut%0d", i), 32'(act[i]), 32'(expect_of(model[i], m12_of(i))));
      @(negedge clk);
      rst_n = 1'b1;
      pulse_start();
      run(9);

      repeat (2) @(negedge clk);
      check_output("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bcd_clock_core.md
# bcd_clock_core

Parametrised time-of-day counter that replaces the separate seconds/minutes/hours BCD counters with one block: a prescaler, cascaded seconds/minutes/hours BCD digits, 12- or 24-hour mode, time load with range checking, a minute-resolution alarm and a day-wrap pulse. It sits between the system clock and the display driver. All carry logic between digits is internal.

## Interface
- TICK_DIV, 50_000_000: clk cycles per one-second tick; legal range 1..2^26; 1 is used for simulation.
- HOUR_MODE, 24: 24 gives hours 00..23; 12 gives hours 01..12 plus a pm flag.

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear pulse
- start_stop  in  1  single-cycle pulse; toggles the run state
- load  in  1  single-cycle pulse; loads load_* values
- load_hour / load_min / load_sec  in  8 each  BCD {tens, units}
- load_pm  in  1  pm flag for the load; used only in 12-hour mode
- alarm_en  in  1  alarm enable (level)
- alarm_hour / alarm_min  in  8 each  BCD alarm time
- alarm_pm  in  1  alarm pm flag; used only in 12-hour mode
- sec_h, sec_l, min_h, min_l, hour_h, hour_l  out  4 each  current time, BCD digits
- pm  out  1  pm flag; constant 0 when HOUR_MODE=24
- running  out  1  run state
- day_carry  out  1  one-cycle pulse on day wrap
- alarm_hit  out  1  one-cycle alarm pulse
- load_err  out  1  one-cycle pulse on a rejected load

## Operation
- Prescaler
  - Counts 0..TICK_DIV-1 while running=1 and holds its value while stopped.
  - An internal tick is asserted in the cycle where the count equals TICK_DIV-1 and running=1; the count then wraps to 0.
- Tick cascade
  - sec_l 9→0 carries into sec_h; sec_h 5→0 carries into minutes. Minutes use the same 0..59 rule.
  - A minute carry is produced only on the tick that moves 59 s to 00 s.
  - An hour carry is produced only on the tick that moves 59:59 to 00:00.
- Hour counting
  - 24-hour mode: 23→00.
  - 12-hour mode: 11→12 toggles pm; 12→01 leaves pm unchanged.
- Day wrap
  - 24-hour mode: 23:59:59 → 00:00:00.
  - 12-hour mode: 11:59:59 pm → 12:00:00 am.
  - day_carry pulses for one cycle on the edge where the wrap happens.
- start_stop toggles running. Multi-cycle pulses are not supported: each high cycle toggles.
- clear
  - Time becomes the zero time: 00:00:00 (24-hour mode) or 12:00:00 am (12-hour mode).
  - Also sets running=0 and prescaler=0.
  - start_stop in the same cycle is ignored.
- load
  - Legal fields: digits ≤ 9, minutes and seconds 00..59, hours 00..23 (24-hour) or 01..12 (12-hour).
  - If every field is legal: the time (and pm) is written, the prescaler is set to 0 and running is unchanged.
  - If any field is illegal: the time is unchanged and load_err pulses.
- Priority in a single cycle: reset > clear > load > tick. A tick coincident with a load or clear is discarded.
- Alarm
  - alarm_hit pulses when a tick moves the time to alarm_hour:alarm_min:00 (and pm equals alarm_pm in 12-hour mode) while alarm_en=1.
  - A load to a matching time never fires the alarm.
  - Illegal alarm values simply never match.

## Timing
- Reset values:
  - Time is the zero time.
  - pm=0, running=0, prescaler=0.
  - day_carry=0, alarm_hit=0, load_err=0.
- All outputs are registered; there are no combinational input-to-output paths.
- A start_stop pulse sampled at edge E0 gives running=1 after E0. The first increment is visible after edge E0+TICK_DIV.
- Stopping at edge Es freezes both the time and the prescaler count. Resuming continues from the frozen count, so the partial second is preserved.
- load and clear take effect on the sampling edge and are visible the next cycle.
- day_carry and alarm_hit are asserted in the same cycle as the digit update that causes them.
- load_err is asserted the cycle after the rejected load.
- Asserting rst_n low mid-count forces the reset values immediately, without waiting for a clock edge.

## Test plan
- TICK_DIV=1, HOUR_MODE=24:
  - Stimulus: release reset, pulse start_stop, run 60 cycles.
  - Required: time reads 00:01:00; minutes stepped exactly once, at the 60th tick.
- TICK_DIV=4, HOUR_MODE=24:
  - Stimulus: load 23:59:58, pulse start_stop.
  - Required: 23:59:59 appears after 4 cycles; 00:00:00 with a one-cycle day_carry after 8 cycles.
- HOUR_MODE=12:
  - Stimulus: load 11:59:59 am and tick.
  - Required: 12:00:00 pm, day_carry=0.
  - Stimulus: load 11:59:59 pm and tick.
  - Required: 12:00:00 am, day_carry=1.
- TICK_DIV=4, pause/resume:
  - Stimulus: start, stop after 6 cycles, wait 20 cycles, resume.
  - Required: the time holds at 00:00:01; the next increment arrives 2 cycles after resume.
- Load checking:
  - Stimulus: load 24:00:00 in 24-hour mode, then load 12:5A:00.
  - Required: load_err pulses for each; time unchanged.
  - Stimulus: load 00:00:00 in 12-hour mode.
  - Required: rejected.
- Alarm and priority:
  - Stimulus: alarm 07:30, alarm_en=1, load 07:29:59, run.
  - Required: alarm_hit pulses exactly once, at 07:30:00.
  - Stimulus: clear asserted in the same cycle as a tick.
  - Required: 00:00:00, running=0, no day_carry or alarm_hit.
